// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the multicycle CPU control core.
// Contents: controller state enum, special opcodes, condition codes and
// instruction field positions/widths.
package cpu_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned COND_W   = 4;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned SHCTRL_W = 3;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned NZCV_W   = 4;

  // Instruction field LSB positions (imm overlaps rs1/rs2/shamt by design)
  localparam int unsigned COND_LSB   = 28;
  localparam int unsigned OP_LSB     = 24;
  localparam int unsigned S_BIT      = 23;
  localparam int unsigned RD_LSB     = 19;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned SHCTRL_LSB = 0;
  localparam int unsigned IMM_LSB    = 3;

  // NZCV bit positions inside the flag nibble
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Opcodes the controller handles itself; all others go to the ALU
  localparam logic [OP_W-1:0] OP_LDR = 4'hD;
  localparam logic [OP_W-1:0] OP_STR = 4'hE;
  localparam logic [OP_W-1:0] OP_B   = 4'hF;

  localparam logic [COND_W-1:0] COND_AL = 4'h0;
  localparam logic [COND_W-1:0] COND_EQ = 4'h1;
  localparam logic [COND_W-1:0] COND_NE = 4'h2;
  localparam logic [COND_W-1:0] COND_CS = 4'h3;
  localparam logic [COND_W-1:0] COND_CC = 4'h4;
  localparam logic [COND_W-1:0] COND_MI = 4'h5;
  localparam logic [COND_W-1:0] COND_PL = 4'h6;
  localparam logic [COND_W-1:0] COND_VS = 4'h7;
  localparam logic [COND_W-1:0] COND_VC = 4'h8;
  localparam logic [COND_W-1:0] COND_HI = 4'h9;
  localparam logic [COND_W-1:0] COND_LS = 4'hA;
  localparam logic [COND_W-1:0] COND_GE = 4'hB;
  localparam logic [COND_W-1:0] COND_LT = 4'hC;
  localparam logic [COND_W-1:0] COND_GT = 4'hD;
  localparam logic [COND_W-1:0] COND_LE = 4'hE;
  localparam logic [COND_W-1:0] COND_NV = 4'hF;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_cond_check.sv
// cpu_cond_check: combinational condition-code evaluation.
// Ports: cond (4-bit condition code), nzcv (current flags),
//        pass_c (1 = instruction should execute).
module cpu_cond_check
  import cpu_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [NZCV_W-1:0] nzcv,
  output logic              pass_c
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass_c = 1'b0;
    case (cond)
      COND_AL: pass_c = 1'b1;
      COND_EQ: pass_c = z;
      COND_NE: pass_c = !z;
      COND_CS: pass_c = c;
      COND_CC: pass_c = !c;
      COND_MI: pass_c = n;
      COND_PL: pass_c = !n;
      COND_VS: pass_c = v;
      COND_VC: pass_c = !v;
      COND_HI: pass_c = c && !z;
      COND_LS: pass_c = !c || z;
      COND_GE: pass_c = (n == v);
      COND_LT: pass_c = (n != v);
      COND_GT: pass_c = !z && (n == v);
      COND_LE: pass_c = z || (n != v);
      COND_NV: pass_c = 1'b0;
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_seq_core.sv
// cpu_seq_core: multicycle CPU control core (PC, IR, NZCV, LOAD/FETCH/
// DECODE/EXECUTE/MEM sequencing) driving an external register file, ALU and
// a req/ready memory port.
// Ports: clk/rst (async active-low); mem_* memory handshake; rd/rs1/rs2_idx,
//        rs1/rs2_data, rf_we, rf_wsel register file; opcode/s/shamt/shctrl/
//        imm/alu_flags ALU; flags architectural NZCV; busy (low only in LOAD).
// Optional: define CPU_PERF_CNT_EN to add cycle_cnt and instr_cnt outputs.
module cpu_seq_core
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic [REG_W-1:0]    rd_idx,
  output logic [REG_W-1:0]    rs1_idx,
  output logic [REG_W-1:0]    rs2_idx,
  input  logic [DATA_W-1:0]   rs1_data,
  input  logic [DATA_W-1:0]   rs2_data,
  output logic                rf_we,
  output logic                rf_wsel,
  output logic [OP_W-1:0]     opcode,
  output logic                s,
  output logic [SHAMT_W-1:0]  shamt,
  output logic [SHCTRL_W-1:0] shctrl,
  output logic [IMM_W-1:0]    imm,
  input  logic [NZCV_W-1:0]   alu_flags,
  output logic [NZCV_W-1:0]   flags,
  output logic                busy
`ifdef CPU_PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instr_cnt
`endif
);

  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    pc, pc_nxt;
  logic [INSTR_W-1:0]   ir, ir_nxt;
  logic [NZCV_W-1:0]    flags_nxt;
  logic [COND_W-1:0]    ir_cond;
  logic [REG_W-1:0]     ir_rd;
  logic [REG_W-1:0]     ir_rs1;
  logic                 cond_pass_c;
  logic                 unused_bits;

  // Instruction fields decoded straight from IR (zero while IR is reset)
  assign ir_cond = ir[COND_LSB +: COND_W];
  assign ir_rd   = ir[RD_LSB +: REG_W];
  assign ir_rs1  = ir[RS1_LSB +: REG_W];
  assign opcode  = ir[OP_LSB +: OP_W];
  assign s       = ir[S_BIT];
  assign rs1_idx = ir_rs1;
  assign rs2_idx = ir[RS2_LSB +: REG_W];
  assign shamt   = ir[SHAMT_LSB +: SHAMT_W];
  assign shctrl  = ir[SHCTRL_LSB +: SHCTRL_W];
  assign imm     = ir[IMM_LSB +: IMM_W];
  assign busy    = (state != ST_LOAD);

  // Upper data bits beyond the instruction/address width are intentionally dropped
  assign unused_bits = ^{mem_rdata, rs2_data};

  cpu_cond_check u_cond (
    .cond   (ir_cond),
    .nzcv   (flags),
    .pass_c (cond_pass_c)
  );

  // State and architectural registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_LOAD;
      pc    <= RESET_PC_A;
      ir    <= '0;
      flags <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      flags <= flags_nxt;
    end
  end

  // Next-state, register updates and handshake outputs
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    flags_nxt = flags;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_idx    = ir_rd;
    rf_we     = 1'b0;
    rf_wsel   = 1'b0;

    case (state)
      ST_LOAD: begin
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) begin
          ir_nxt    = mem_rdata[INSTR_W-1:0];
          state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (!cond_pass_c) begin
          // Skipped instruction retires here without touching RF or flags
          pc_nxt    = pc + PC_ONE;
          state_nxt = ST_FETCH;
        end else if (opcode == OP_LDR || opcode == OP_STR) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        state_nxt = ST_FETCH;
        if (opcode == OP_B) begin
          pc_nxt = ADDR_W'(imm);
        end else begin
          rf_we  = 1'b1;
          pc_nxt = pc + PC_ONE;
          if (s) begin
            flags_nxt = alu_flags;
          end
        end
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = rs2_data[ADDR_W-1:0];
        if (opcode == OP_STR) begin
          mem_we    = 1'b1;
          mem_wdata = rs1_data;
        end else begin
          // LDR targets the register named in the rs1 field
          rd_idx  = ir_rs1;
          rf_wsel = 1'b1;
          rf_we   = mem_ready;
        end
        if (mem_ready) begin
          pc_nxt    = pc + PC_ONE;
          state_nxt = ST_FETCH;
        end
      end

      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

`ifdef CPU_PERF_CNT_EN
  // Performance counters: active cycles and retired instructions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != ST_LOAD) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if ((state == ST_DECODE && !cond_pass_c) ||
          (state == ST_EXECUTE) ||
          (state == ST_MEM && mem_ready)) begin
        instr_cnt <= instr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cpu_seq_core.md
# cpu_seq_core

Parametrised multicycle CPU control core: program counter, instruction register, NZCV flag register, condition evaluation and a fetch/decode/execute/memory state machine driving an external register file, ALU and memory through a req/ready handshake. It replaces fixed-timing single-cycle memory reads with wait-state-tolerant accesses and adds branching, stores and condition-fail skipping. It sits between the memory controller and the datapath.

## Interface
Parameters:
- DATA_W, 32, datapath width (≥32; instruction is mem_rdata[31:0])
- ADDR_W, 16, word-address and PC width (1..32)
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1
- mem_ready  in  1  access completes on this edge
- rd_idx / rs1_idx / rs2_idx  out  4  register indices
- rs1_data / rs2_data  in  DATA_W  register read data
- rf_we  out  1  register write strobe
- rf_wsel  out  1  0 = alu_result, 1 = mem_rdata
- opcode  out  4, s  out  1, shamt  out  5, shctrl  out  3, imm  out  16  ALU controls
- alu_flags  in  4  NZCV from ALU
- flags  out  4  architectural NZCV
- busy  out  1  high outside FETCH-wait idle; low only in LOAD

## Operation
- Instruction fields: cond[31:28], opcode[27:24], s[23], rd[22:19], rs1[18:15], rs2[14:11], shamt[10:6], shctrl[2:0], imm[18:3].
- States: LOAD → FETCH → DECODE → {EXECUTE | MEM} → FETCH.
- LOAD: one cycle after reset release; no outputs asserted.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc; IR ← mem_rdata[31:0] on edge with mem_ready.
- DECODE: fields drive outputs from IR. Condition false → pc ← pc+1, go FETCH. LDR (1101) / STR (1110) → MEM. Otherwise → EXECUTE.
- EXECUTE: ALU ops: rf_we=1, rf_wsel=0, rd_idx=rd; if s=1 flags ← alu_flags. B (1111): no write, pc ← imm zero-extended/truncated to ADDR_W. Else pc ← pc+1.
- MEM: mem_addr=rs2_data[ADDR_W-1:0]; LDR: rd_idx=rs1 field, rf_we=mem_ready, rf_wsel=1; STR: mem_we=1, mem_wdata=rs1_data. pc ← pc+1 on ready.
- Conditions (cond code → test): 0 AL, 1 EQ Z, 2 NE !Z, 3 CS C, 4 CC !C, 5 MI N, 6 PL !N, 7 VS V, 8 VC !V, 9 HI C&!Z, A LS !C|Z, B GE N=V, C LT N≠V, D GT !Z&N=V, E LE Z|N≠V, F NV never.
- PC arithmetic modulo 2^ADDR_W; pc = all-ones increments to 0.

## Timing
- Reset values: pc=RESET_PC, state=LOAD, IR=0, flags=0, mem_req=0, mem_we=0, rf_we=0, busy=0, all field outputs 0.
- mem_req, mem_addr, mem_we, mem_wdata stable from assertion until the mem_ready edge; mem_ready while mem_req=0 is ignored.
- Zero-wait latency: ALU/B = 3 cycles, LDR/STR = 3 cycles, condition-fail = 2 cycles; each wait state adds 1.
- rf_we is a single-cycle pulse, never asserted in FETCH/DECODE/LOAD.
- Flags written only in EXECUTE; condition evaluated in DECODE against current flags.
- Reset mid-access: abandons access, mem_req drops asynchronously, no register write or flag update.

## Configuration
- CPU_PERF_CNT_EN defined: adds outputs cycle_cnt (32, counts every non-LOAD cycle) and instr_cnt (32, counts retired instructions incl. condition-fail skips), both reset to 0, wrap at 2^32. Undefined: ports and counters absent, behaviour otherwise identical.

## Structure
- Package cpu_pkg: state enum, opcode constants (LDR, STR, B), cond-code constants, instruction field position constants.
- One sub-module cpu_cond_check (combinational cond + NZCV → pass).

## Test plan
- Zero-wait ALU op, cond=0, s=1, alu_flags=4'b0100 → rf_we pulse in cycle 3, flags=0100, pc 0→1.
- Fetch with 2 wait states → mem_req high 3 cycles, addr constant, IR loaded on ready edge, total 5 cycles.
- cond=1 (EQ) with Z=0 → no rf_we, no MEM, pc+1 after 2 cycles; with Z=1 → executes.
- LDR rs1=3, rs2_data=0x20, mem_rdata=0xDEADBEEF → mem_addr=0x20, rd_idx=3, rf_wsel=1, rf_we on ready; STR → mem_we=1, mem_wdata=rs1_data.
- B imm=0x0040 → next fetch addr 0x40; pc=0xFFFF ALU op (ADDR_W=16) → next fetch addr 0.
- rst low during MEM wait → mem_req 0 immediately, pc=RESET_PC, flags=0, LOAD then FETCH after release.
